sumador_checker: RTL and testbench

// - Receive-side monitor for the sumador counter stream (out[7:0] + cout).
// - Tracks the counter value and its enable, predicts each next value and carry,
//   and flags any mismatch.
// - Counts carry-validated wraps and errors.
// - Sits beside the sumador in the tt_um top; its outputs are exposed on spare uio pins.

---
 rtl/sumador_checker.sv | 170 +++++++++++++++++
 tb/tb_sumador_checker.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/sumador_checker.sv
// sumador_checker: receive-side monitor for the sumador counter stream.
// Predicts each next counter value and carry from the previous sample and
// the enable seen one cycle earlier, locks after LOCK_CYCLES consecutive good
// predictions, then counts errors (saturating) and carry-validated wraps.
//
// Build option: define SUMADOR_CHK_STICKY_EN to make err_flag sticky until
// err_clr (or reset). Without it err_flag is a one-cycle pulse per mismatch
// and err_clr is ignored.
module sumador_checker #(
  parameter int WIDTH       = 8,
  parameter int LOCK_CYCLES = 4,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_in,
  input  logic [WIDTH-1:0] cnt_in,
  input  logic             cout_in,
  input  logic             err_clr,
  output logic             locked,
  output logic             err_flag,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] wrap_count
);

  // Match counter only needs to reach LOCK_CYCLES-1; keep at least one bit.
  localparam int MC_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [MC_W-1:0]  MC_LAST  = MC_W'(LOCK_CYCLES - 1);
  localparam logic [WIDTH-1:0] CNT_ONES = {WIDTH{1'b1}};
  localparam logic [CNT_W-1:0] SAT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [0:0] {
    ST_SYNC  = 1'b0,
    ST_TRACK = 1'b1
  } state_e;

  // State and datapath registers
  state_e           state_q, state_d;
  logic [WIDTH-1:0] prev_q;
  logic             en_q;
  logic             prev_vld_q, prev_vld_d;
  logic [MC_W-1:0]  match_cnt_q, match_cnt_d;
  logic             locked_q, locked_d;
  logic             err_flag_q, err_flag_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;
  logic [CNT_W-1:0] wrap_count_q, wrap_count_d;

  // Prediction and compare results
  logic [WIDTH-1:0] exp_val_s;
  logic             exp_c_s;
  logic             match_s;
  logic             trk_err_s;
  logic             trk_wrap_s;

  // Predict the value/carry the counter should present this cycle.
  always_comb begin
    exp_val_s = prev_q + WIDTH'(en_q);
    exp_c_s   = en_q & (prev_q == CNT_ONES);
    match_s   = (cnt_in == exp_val_s) && (cout_in == exp_c_s);
  end

  // Lock FSM: next state, match counter and per-cycle track events.
  always_comb begin
    state_d     = state_q;
    prev_vld_d  = 1'b1;
    match_cnt_d = match_cnt_q;
    trk_err_s   = 1'b0;
    trk_wrap_s  = 1'b0;
    case (state_q)
      ST_SYNC: begin
        if (!prev_vld_q) begin
          // First cycle after reset/resync: only load prev, no compare.
          match_cnt_d = {MC_W{1'b0}};
        end else if (match_s) begin
          if (match_cnt_q == MC_LAST) begin
            state_d     = ST_TRACK;
            match_cnt_d = {MC_W{1'b0}};
          end else begin
            match_cnt_d = match_cnt_q + {{(MC_W-1){1'b0}}, 1'b1};
          end
        end else begin
          // Mismatch while hunting for lock is not an error, just restart.
          match_cnt_d = {MC_W{1'b0}};
        end
      end
      ST_TRACK: begin
        if (match_s) begin
          trk_wrap_s = cout_in;
        end else begin
          trk_err_s   = 1'b1;
          state_d     = ST_SYNC;
          prev_vld_d  = 1'b0;
          match_cnt_d = {MC_W{1'b0}};
        end
      end
      default: begin
        state_d     = ST_SYNC;
        prev_vld_d  = 1'b0;
        match_cnt_d = {MC_W{1'b0}};
      end
    endcase
  end

  // Output-side next values: lock indication, error flag, counters.
  always_comb begin
    locked_d = (state_d == ST_TRACK);

    if (trk_err_s && (err_count_q != SAT_MAX)) begin
      err_count_d = err_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      err_count_d = err_count_q;
    end

    if (trk_wrap_s) begin
      wrap_count_d = wrap_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      wrap_count_d = wrap_count_q;
    end

`ifdef SUMADOR_CHK_STICKY_EN
    // Sticky: a new mismatch wins over a simultaneous clear.
    if (trk_err_s) begin
      err_flag_d = 1'b1;
    end else if (err_clr) begin
      err_flag_d = 1'b0;
    end else begin
      err_flag_d = err_flag_q;
    end
`else
    err_flag_d = trk_err_s;
`endif
  end

`ifndef SUMADOR_CHK_STICKY_EN
  // err_clr has no function in the pulse build.
  logic unused_err_clr_s;
  assign unused_err_clr_s = err_clr;
`endif

  // Register all state; async reset returns every output to zero at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_SYNC;
      prev_q       <= {WIDTH{1'b0}};
      en_q         <= 1'b0;
      prev_vld_q   <= 1'b0;
      match_cnt_q  <= {MC_W{1'b0}};
      locked_q     <= 1'b0;
      err_flag_q   <= 1'b0;
      err_count_q  <= {CNT_W{1'b0}};
      wrap_count_q <= {CNT_W{1'b0}};
    end else begin
      state_q      <= state_d;
      prev_q       <= cnt_in;
      en_q         <= en_in;
      prev_vld_q   <= prev_vld_d;
      match_cnt_q  <= match_cnt_d;
      locked_q     <= locked_d;
      err_flag_q   <= err_flag_d;
      err_count_q  <= err_count_d;
      wrap_count_q <= wrap_count_d;
    end
  end

  assign locked     = locked_q;
  assign err_flag   = err_flag_q;
  assign err_count  = err_count_q;
  assign wrap_count = wrap_count_q;

endmodule

// File: tb/tb_sumador_checker.sv
// Testbench for sumador_checker: table of per-cycle vectors with expected
// outputs, plus hand-written saturation and async-reset sequences.
module tb_sumador_checker;

`ifdef SUMADOR_CHK_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       en_in;
  logic [7:0] cnt_in;
  logic       cout_in;
  logic       err_clr;
  logic       locked;
  logic       err_flag;
  logic [7:0] err_count;
  logic [7:0] wrap_count;

  int n_cmp = 0;
  int n_err = 0;

  sumador_checker #(.WIDTH(8), .LOCK_CYCLES(4), .CNT_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en_in      (en_in),
    .cnt_in     (cnt_in),
    .cout_in    (cout_in),
    .err_clr    (err_clr),
    .locked     (locked),
    .err_flag   (err_flag),
    .err_count  (err_count),
    .wrap_count (wrap_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;   // rst_n value for this cycle
    logic       en;
    logic [7:0] cnt;
    logic       cout;
    logic       clr;
    logic       lk;    // expected locked after the edge
    logic       mis;   // a TRACK mismatch is expected at this edge
    logic [7:0] ec;    // expected err_count
    logic [7:0] wc;    // expected wrap_count
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rst, input logic en, input logic [7:0] cnt,
                     input logic cout, input logic clr, input logic lk,
                     input logic mis, input logic [7:0] ec, input logic [7:0] wc);
    vec_t v;
    v.rst = rst; v.en = en; v.cnt = cnt; v.cout = cout; v.clr = clr;
    v.lk = lk; v.mis = mis; v.ec = ec; v.wc = wc;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Apply one cycle of inputs (en=1, no clear), return 1 time unit after the edge.
  task automatic drive(input logic [7:0] cnt, input logic cout);
    en_in = 1'b1; cnt_in = cnt; cout_in = cout; err_clr = 1'b0;
    @(posedge clk);
    #1;
  endtask

  logic       ef_model;
  logic [7:0] cur;
  logic [7:0] ec_exp;

  initial begin
    rst_n = 1'b0; en_in = 1'b0; cnt_in = 8'h00; cout_in = 1'b0; err_clr = 1'b0;
    ef_model = 1'b0;

    // Segment A: lock from 0x00, inject error, relock, static counter.
    add(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    for (int i = 0; i < 4; i++) add(1'b1, 1'b1, 8'(i), 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    for (int i = 4; i < 7; i++) add(1'b1, 1'b1, 8'(i), 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0);
    add(1'b1, 1'b1, 8'h08, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1, 8'd0);
    for (int i = 9; i < 13; i++) add(1'b1, 1'b1, 8'(i), 1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 8'd0);
    add(1'b1, 1'b1, 8'h0D, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1, 8'd0);
    add(1'b1, 1'b0, 8'h0E, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1, 8'd0);
    add(1'b1, 1'b0, 8'h0E, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1, 8'd0);
    add(1'b1, 1'b1, 8'h0E, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1, 8'd0);
    add(1'b1, 1'b1, 8'h0F, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1, 8'd0);
    // Segment B: good wrap with carry, then carry off-wrap.
    add(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    for (int i = 8'hFB; i < 8'hFF; i++) add(1'b1, 1'b1, 8'(i), 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    add(1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0);
    add(1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0, 8'd1);
    add(1'b1, 1'b1, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8'd1);
    add(1'b1, 1'b1, 8'h02, 1'b1, 1'b0, 1'b0, 1'b1, 8'd1, 8'd1);
    add(1'b1, 1'b1, 8'h03, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 8'd1);
    // Segment C: wrap without carry, then a SYNC-phase mismatch restarts lock.
    add(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    for (int i = 8'hFB; i < 8'hFF; i++) add(1'b1, 1'b1, 8'(i), 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    add(1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0);
    add(1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1, 8'd0);
    for (int i = 1; i < 4; i++) add(1'b1, 1'b1, 8'(i), 1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 8'd0);
    add(1'b1, 1'b1, 8'h05, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 8'd0);
    for (int i = 6; i < 9; i++) add(1'b1, 1'b1, 8'(i), 1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 8'd0);
    add(1'b1, 1'b1, 8'h09, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1, 8'd0);
    // Segment D: 0x42 where 0x41 expected, relock, then err_clr behaviour.
    add(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    for (int i = 8'h3C; i < 8'h40; i++) add(1'b1, 1'b1, 8'(i), 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    add(1'b1, 1'b1, 8'h40, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0);
    add(1'b1, 1'b1, 8'h42, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1, 8'd0);
    for (int i = 8'h43; i < 8'h47; i++) add(1'b1, 1'b1, 8'(i), 1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 8'd0);
    add(1'b1, 1'b1, 8'h47, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1, 8'd0);
    add(1'b1, 1'b1, 8'h48, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1, 8'd0);
    add(1'b1, 1'b1, 8'h4A, 1'b0, 1'b1, 1'b0, 1'b1, 8'd2, 8'd0);
    for (int i = 8'h4B; i < 8'h4F; i++) add(1'b1, 1'b1, 8'(i), 1'b0, 1'b0, 1'b0, 1'b0, 8'd2, 8'd0);
    for (int i = 8'h4F; i < 8'h55; i++) add(1'b1, 1'b1, 8'(i), 1'b0, 1'b0, 1'b1, 1'b0, 8'd2, 8'd0);
    add(1'b1, 1'b1, 8'h55, 1'b0, 1'b1, 1'b1, 1'b0, 8'd2, 8'd0);
    add(1'b1, 1'b1, 8'h56, 1'b0, 1'b0, 1'b1, 1'b0, 8'd2, 8'd0);

    #2;
    for (int i = 0; i < tbl.size(); i++) begin
      rst_n = tbl[i].rst; en_in = tbl[i].en; cnt_in = tbl[i].cnt;
      cout_in = tbl[i].cout; err_clr = tbl[i].clr;
      @(posedge clk);
      #1;
      if (!tbl[i].rst)                 ef_model = 1'b0;
      else if (tbl[i].mis)             ef_model = 1'b1;
      else if (!STICKY)                ef_model = 1'b0;
      else if (tbl[i].clr)             ef_model = 1'b0;
      else                             ef_model = ef_model;
      chk($sformatf("v%0d locked", i),     {7'd0, locked},   {7'd0, tbl[i].lk});
      chk($sformatf("v%0d err_flag", i),   {7'd0, err_flag}, {7'd0, ef_model});
      chk($sformatf("v%0d err_count", i),  err_count,        tbl[i].ec);
      chk($sformatf("v%0d wrap_count", i), wrap_count,       tbl[i].wc);
    end

    // Saturation: 300 injected mismatches with a relock between each.
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cur = 8'h00;
    drive(cur, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cur = cur + 8'd1;
      drive(cur, cur == 8'h00);
    end
    chk("sat initial lock", {7'd0, locked}, 8'd1);
    for (int k = 1; k <= 300; k++) begin
      cur = cur + 8'd2;
      drive(cur, 1'b0);
      ec_exp = (k > 255) ? 8'hFF : 8'(k);
      chk($sformatf("sat err_count k=%0d", k), err_count, ec_exp);
      for (int j = 0; j < 5; j++) begin
        cur = cur + 8'd1;
        drive(cur, cur == 8'h00);
      end
    end
    chk("sat relocked", {7'd0, locked}, 8'd1);

    // Async reset mid-TRACK: outputs clear without waiting for a clock edge.
    rst_n = 1'b0;
    #1;
    chk("async locked",     {7'd0, locked},   8'd0);
    chk("async err_flag",   {7'd0, err_flag}, 8'd0);
    chk("async err_count",  err_count,        8'd0);
    chk("async wrap_count", wrap_count,       8'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
